// File: rtl/fir_out_pkg.sv
// rtl/fir_out_pkg.sv - shared defaults and round/shift/saturate helper for the FIR output path
package fir_out_pkg;

    localparam int ACC_W_DEF = 32;
    localparam int OUT_W_DEF = 16;
    localparam int SHIFT_DEF = 15;
    localparam int TAPS_DEF  = 15;
    localparam int RQ_W      = 64;

    localparam logic [RQ_W:0] RQ_ONE = {{RQ_W{1'b0}}, 1'b1};

    // Round half up, shift right, clamp to out_w bits; one guard bit keeps the rounding add exact.
    function automatic logic [RQ_W-1:0] sat_round(input logic [RQ_W-1:0] x, input int shift,
                                                  input int out_w, output logic sat);
        logic [RQ_W:0] t;
        logic [RQ_W:0] q;
        logic [RQ_W:0] max_v;
        t = {1'b0, x};
        if (shift > 0) begin
            t = t + (RQ_ONE << (shift - 1));
        end
        q     = t >> shift;
        max_v = (RQ_ONE << out_w) - RQ_ONE;
        sat   = (q > max_v);
        return sat ? max_v[RQ_W-1:0] : q[RQ_W-1:0];
    endfunction

endpackage

// File: rtl/fir_requant_decimator_if.sv
// rtl/fir_requant_decimator_if.sv - valid/ready output stream of the requantizing decimator
interface fir_requant_decimator_if
    import fir_out_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF
) ();
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through synchronous FIFO, power-of-two depth
module sync_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)      count <= count + CNT_ONE;
            else if (!do_push && do_pop) count <= count - CNT_ONE;
        end
    end
endmodule

// File: rtl/fir_requant_decimator.sv
// rtl/fir_requant_decimator.sv - requantizes FIR accumulator output, drops warm-up, decimates, buffers
module fir_requant_decimator
    import fir_out_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = SHIFT_DEF,
    parameter int TAPS  = TAPS_DEF,
    parameter int DECIM = 4,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ACC_W-1:0]          filtered_signal,
    input  logic                      in_valid,
    input  logic                      clr_flags,
    fir_requant_decimator_if.master   m_out,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      sat_flag,
    output logic                      overflow
);
    localparam int WU_W = $clog2(TAPS + 1);
    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [WU_W-1:0] WU_LAST = WU_W'(TAPS - 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

    logic [WU_W-1:0]  wu_cnt;
    logic [PH_W-1:0]  phase;
    logic [OUT_W-1:0] q_reg;
    logic             q_valid;
    logic             q_keep;
    logic [RQ_W-1:0]  rq;
    logic             rq_sat;
    logic             unused_rq_hi;
    logic             eligible;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    always_comb begin
        rq_sat = 1'b0;
        rq     = sat_round(RQ_W'(filtered_signal), SHIFT, OUT_W, rq_sat);
    end
    assign unused_rq_hi = ^rq[RQ_W-1:OUT_W];

    // Keep/drop is decided on arrival and travels with the quantized sample.
    assign eligible = in_valid && (wu_cnt == WU_LAST);
    assign push     = q_valid && q_keep;
    assign pop      = m_out.out_valid && m_out.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wu_cnt   <= '0;
            phase    <= '0;
            q_reg    <= '0;
            q_valid  <= 1'b0;
            q_keep   <= 1'b0;
            sat_flag <= 1'b0;
            overflow <= 1'b0;
        end else begin
            q_valid <= in_valid;
            q_keep  <= eligible && (phase == '0);
            if (in_valid) begin
                q_reg <= rq[OUT_W-1:0];
                if (wu_cnt != WU_LAST) wu_cnt <= wu_cnt + WU_W'(1);
            end
            if (eligible) begin
                phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
            end
            if (in_valid && rq_sat) sat_flag <= 1'b1;
            else if (clr_flags)     sat_flag <= 1'b0;
            if (push && full && !pop) overflow <= 1'b1;
            else if (clr_flags)       overflow <= 1'b0;
        end
    end

    assign m_out.out_valid = !empty;

    sync_fifo_fwft #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (q_reg),
        .pop       (pop),
        .pop_data  (m_out.out_data),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );
endmodule
